// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle logic ops and iterative MUL/DIV/MOD engines.
// Build option: define SEQ_ALU_STICKY_ERROR_EN to make `error` sticky until CLEAR or reset.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] prev_result,
    output logic             error,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_NOT   = 4'd7;
    localparam logic [3:0] OP_MOD   = 4'd8;
    localparam logic [3:0] OP_NAND  = 4'd9;
    localparam logic [3:0] OP_NOR   = 4'd10;
    localparam logic [3:0] OP_XNOR  = 4'd11;
    localparam logic [3:0] OP_SUB   = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;
    localparam logic [3:0] OP_SLL   = 4'd14;
    localparam logic [3:0] OP_CLEAR = 4'd15;

`ifdef SEQ_ALU_STICKY_ERROR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    // hi/lo hold {product} for MUL and {remainder, dividend/quotient} for DIV/MOD
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic             iter_q, iter_d, flag_q, flag_d;
    logic [WIDTH-1:0] result_q, result_d, prev_q, prev_d;
    logic             error_q, error_d, out_valid_q, out_valid_d;

    logic             accept;
    logic             is_iter;
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] imm_res;
    logic             imm_err;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] fin_res;
    logic             fin_err;

    assign in_ready    = (state_q == S_IDLE) && !reset;
    assign accept      = in_valid && in_ready;
    assign is_iter     = (opcode == OP_MUL) ||
                         (((opcode == OP_DIV) || (opcode == OP_MOD)) && (b_in != {WIDTH{1'b0}}));
    assign shamt       = b_in[SW-1:0];
    assign add_sum     = {1'b0, a_in} + {1'b0, b_in};
    assign mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign div_trial   = {hi_q, lo_q[WIDTH-1]};
    assign div_ge      = (div_trial >= {1'b0, b_q});
    // When div_ge holds the true difference is below b_q, so the low WIDTH bits are exact
    assign div_diff    = div_trial[WIDTH-1:0] - b_q;

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign prev_result = prev_q;
    assign error       = error_q;
    assign busy        = (state_q != S_IDLE);

    // Result of ops that complete without the iterative engine (incl. divide by zero)
    always_comb begin
        imm_res = {WIDTH{1'b0}};
        imm_err = 1'b0;
        case (opcode)
            OP_NOOP: imm_res = result_q;
            OP_AND:  imm_res = a_in & b_in;
            OP_OR:   imm_res = a_in | b_in;
            OP_XOR:  imm_res = a_in ^ b_in;
            OP_ADD: begin
                imm_res = add_sum[WIDTH-1:0];
                imm_err = add_sum[WIDTH];
            end
            OP_SRL:  imm_res = a_in >> shamt;
            OP_NOT:  imm_res = ~a_in;
            OP_MOD: begin
                imm_res = a_in;
                imm_err = 1'b1;
            end
            OP_NAND: imm_res = ~(a_in & b_in);
            OP_NOR:  imm_res = ~(a_in | b_in);
            OP_XNOR: imm_res = ~(a_in ^ b_in);
            OP_SUB: begin
                imm_res = a_in - b_in;
                imm_err = (a_in < b_in);
            end
            OP_DIV: begin
                imm_res = {WIDTH{1'b1}};
                imm_err = 1'b1;
            end
            OP_SLL:  imm_res = a_in << shamt;
            default: imm_res = {WIDTH{1'b0}};
        endcase
    end

    // Final result/error presented on the DONE->IDLE edge
    always_comb begin
        fin_res = lo_q;
        fin_err = flag_q;
        if (iter_q) begin
            case (op_q)
                OP_MUL: begin
                    fin_res = lo_q;
                    fin_err = |hi_q;
                end
                OP_MOD: begin
                    fin_res = hi_q;
                    fin_err = 1'b0;
                end
                default: begin
                    fin_res = lo_q;
                    fin_err = 1'b0;
                end
            endcase
        end else begin
            fin_res = lo_q;
            fin_err = flag_q;
        end
    end

    // Next-state logic for the FSM, the iterative engine and the output registers
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        b_d         = b_q;
        iter_d      = iter_q;
        flag_d      = flag_q;
        result_d    = result_q;
        prev_d      = prev_q;
        error_d     = error_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = opcode;
                    b_d    = b_in;
                    cnt_d  = {SW{1'b0}};
                    iter_d = is_iter;
                    if (is_iter) begin
                        state_d = S_RUN;
                        hi_d    = {WIDTH{1'b0}};
                        lo_d    = a_in;
                        flag_d  = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        lo_d    = imm_res;
                        flag_d  = imm_err;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (op_q == OP_MUL) begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = div_ge ? div_diff : div_trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b1;
                if (op_q == OP_CLEAR) begin
                    result_d = {WIDTH{1'b0}};
                    prev_d   = {WIDTH{1'b0}};
                    error_d  = 1'b0;
                end else begin
                    result_d = fin_res;
                    prev_d   = result_q;
                    error_d  = fin_err | (STICKY & error_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 4'd0;
            cnt_q       <= {SW{1'b0}};
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            iter_q      <= 1'b0;
            flag_q      <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            prev_q      <= {WIDTH{1'b0}};
            error_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            b_q         <= b_d;
            iter_q      <= iter_d;
            flag_q      <= flag_d;
            result_q    <= result_d;
            prev_q      <= prev_d;
            error_q     <= error_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
